hazard_stall_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage MIPS pipeline. It decides every cycle whether fetch/decode advance or hold.
- Detects load-use hazards between the ID and EX stages.
- Schedules the shared multi-cycle mult/div unit that writes HI/LO, and stalls ID while that unit is busy.
- Drives the PC/nPC load enables, the IF/ID load enable and the ID/EX bubble (NOP insert). Keeps a saturating stall counter for debug.

---
 rtl/hazard_stall_ctrl_pkg.sv | 10 +
 rtl/hazard_stall_ctrl_if.sv | 36 +++
 rtl/hazard_stall_ctrl_md_latency_counter.sv | 24 ++
 rtl/hazard_stall_ctrl.sv | 83 ++++++++
 tb/tb_hazard_stall_ctrl.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the MIPS pipeline sequencing logic.
// Holds the mult/div FSM encoding, the default latencies and the $0 register index.
package mips_pipe_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_e;

  localparam int MULT_LAT_DEF = 4;
  localparam int DIV_LAT_DEF  = 8;

  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Bundle between the ID/EX hazard sources and the stall controller.
// The master drives the decode/execute fields; the slave returns the enables and mult/div status.
interface hazard_stall_ctrl_if #(parameter int STALL_CNT_W = 16);
  logic                   freeze;
  logic [4:0]             id_rs;
  logic [4:0]             id_rt;
  logic                   id_uses_rs;
  logic                   id_uses_rt;
  logic                   ex_load;
  logic [4:0]             ex_rd;
  logic                   id_is_md;
  logic                   id_md_div;
  logic                   id_reads_hilo;
  logic                   pc_le;
  logic                   npc_le;
  logic                   if_id_le;
  logic                   id_ex_bubble;
  logic                   md_start;
  logic                   md_busy;
  logic                   md_done;
  logic [STALL_CNT_W-1:0] stall_count;

  modport master (
    output freeze, id_rs, id_rt, id_uses_rs, id_uses_rt, ex_load, ex_rd,
           id_is_md, id_md_div, id_reads_hilo,
    input  pc_le, npc_le, if_id_le, id_ex_bubble, md_start, md_busy, md_done,
           stall_count
  );

  modport slave (
    input  freeze, id_rs, id_rt, id_uses_rs, id_uses_rt, ex_load, ex_rd,
           id_is_md, id_md_div, id_reads_hilo,
    output pc_le, npc_le, if_id_le, id_ex_bubble, md_start, md_busy, md_done,
           stall_count
  );
endinterface

// File: rtl/hazard_stall_ctrl_md_latency_counter.sv
// Loadable down-counter that times a mult/div operation.
// Load wins over decrement; o_one flags the last busy cycle.
module md_latency_counter #(
  parameter int CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_one
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                  r_cnt <= '0;
    else if (i_load)               r_cnt <= i_load_val;
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end

  assign o_cnt = r_cnt;
  assign o_one = (r_cnt == CNT_W'(1));
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Fetch/decode sequencing: load-use and HI/LO hazard stalls, mult/div scheduling,
// and a saturating count of stalled cycles.
module hazard_stall_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int MULT_LAT    = MULT_LAT_DEF,
  parameter int DIV_LAT     = DIV_LAT_DEF,
  parameter int CNT_W       = 4,
  parameter int STALL_CNT_W = 16
) (
  input logic          Clk,
  input logic          Reset_n,
  hazard_stall_ctrl_if.slave bus
);
  localparam logic [CNT_W-1:0] MULT_LV = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_LV  = CNT_W'(DIV_LAT);

  md_state_e              r_state;
  md_state_e              w_next;
  logic [STALL_CNT_W-1:0] r_stall_cnt;
  logic                   w_load_use;
  logic                   w_md_busy;
  logic                   w_md_conflict;
  logic                   w_stall;
  logic                   w_md_start;
  logic [CNT_W-1:0]       w_cnt;
  logic                   w_cnt_one;

  assign w_load_use = bus.ex_load && (bus.ex_rd != REG_ZERO) &&
                      ((bus.id_uses_rs && (bus.id_rs == bus.ex_rd)) ||
                       (bus.id_uses_rt && (bus.id_rt == bus.ex_rd)));

  assign w_md_busy     = (r_state == BUSY);
  assign w_md_conflict = w_md_busy && (bus.id_is_md || bus.id_reads_hilo);
  // Gated by reset so the pipeline free-runs while Reset_n is low.
  assign w_stall       = Reset_n && (w_load_use || w_md_conflict || bus.freeze);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_md_start = 1'b0;
    case (r_state)
      IDLE: begin
        if (Reset_n && bus.id_is_md && !w_stall) begin
          w_md_start = 1'b1;
          w_next     = BUSY;
        end
      end
      BUSY: begin
        if (w_cnt_one) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  md_latency_counter #(.CNT_W(CNT_W)) u_lat_cnt (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .i_load    (w_md_start),
    .i_load_val(bus.id_md_div ? DIV_LV : MULT_LV),
    .i_dec     (w_md_busy),
    .o_cnt     (w_cnt),
    .o_one     (w_cnt_one)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                         r_stall_cnt <= '0;
    else if (w_stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign bus.pc_le        = !w_stall;
  assign bus.npc_le       = !w_stall;
  assign bus.if_id_le     = !w_stall;
  assign bus.id_ex_bubble = w_stall;
  assign bus.md_start     = w_md_start;
  assign bus.md_busy      = w_md_busy;
  assign bus.md_done      = w_md_busy && w_cnt_one;
  assign bus.stall_count  = r_stall_cnt;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: hazards, mult/div timing, reset abort, saturation.
module tb_hazard_stall_ctrl;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  hazard_stall_ctrl_if #(.STALL_CNT_W(16)) bus ();
  hazard_stall_ctrl_if #(.STALL_CNT_W(4))  bus4 ();

  hazard_stall_ctrl #(.MULT_LAT(4), .DIV_LAT(8), .CNT_W(4), .STALL_CNT_W(16)) u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus)
  );
  hazard_stall_ctrl #(.MULT_LAT(4), .DIV_LAT(8), .CNT_W(4), .STALL_CNT_W(4)) u_dut4 (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus4)
  );

  int errs = 0;
  int checks = 0;
  int exp_sc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(posedge Clk); #1;
  endtask

  task automatic clr_in;
    bus.freeze = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_uses_rs = 0; bus.id_uses_rt = 0;
    bus.ex_load = 0; bus.ex_rd = 0; bus.id_is_md = 0; bus.id_md_div = 0; bus.id_reads_hilo = 0;
    bus4.freeze = 0; bus4.id_rs = 0; bus4.id_rt = 0; bus4.id_uses_rs = 0; bus4.id_uses_rt = 0;
    bus4.ex_load = 0; bus4.ex_rd = 0; bus4.id_is_md = 0; bus4.id_md_div = 0; bus4.id_reads_hilo = 0;
  endtask

  task automatic chk_run(input string tag);
    chk({tag, "_pc"},     bus.pc_le, 1);
    chk({tag, "_npc"},    bus.npc_le, 1);
    chk({tag, "_ifid"},   bus.if_id_le, 1);
    chk({tag, "_bubble"}, bus.id_ex_bubble, 0);
  endtask

  task automatic chk_stall(input string tag);
    chk({tag, "_pc"},     bus.pc_le, 0);
    chk({tag, "_npc"},    bus.npc_le, 0);
    chk({tag, "_ifid"},   bus.if_id_le, 0);
    chk({tag, "_bubble"}, bus.id_ex_bubble, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset values, even with freeze and an md op presented.
    clr_in();
    bus.freeze = 1; bus.id_is_md = 1;
    #3;
    chk_run("rst");
    chk("rst_start", bus.md_start, 0);
    chk("rst_busy",  bus.md_busy, 0);
    chk("rst_done",  bus.md_done, 0);
    chk("rst_sc",    bus.stall_count, 0);
    clr_in();
    @(negedge Clk) Reset_n = 1;

    // Load-use on rs
    nxt(); clr_in();
    bus.ex_load = 1; bus.ex_rd = 5; bus.id_uses_rs = 1; bus.id_rs = 5;
    #3 chk_stall("lu_rs"); exp_sc++;
    nxt(); bus.ex_load = 0;
    #3 chk_run("lu_after");
    chk("lu_sc", bus.stall_count, exp_sc);

    // Load-use on rt
    nxt(); clr_in();
    bus.ex_load = 1; bus.ex_rd = 7; bus.id_uses_rt = 1; bus.id_rt = 7;
    #3 chk_stall("lu_rt"); exp_sc++;
    // Matching rs but not used
    nxt(); clr_in();
    bus.ex_load = 1; bus.ex_rd = 5; bus.id_rs = 5;
    #3 chk_run("lu_unused");
    // Load to $0
    nxt(); clr_in();
    bus.ex_load = 1; bus.ex_rd = 0; bus.id_uses_rs = 1; bus.id_rs = 0;
    #3 chk_run("lu_zero");
    chk("lu_zero_sc", bus.stall_count, exp_sc);

    // mult then mfhi
    nxt(); clr_in();
    bus.id_is_md = 1; bus.id_md_div = 0;
    #3 chk("mul_start", bus.md_start, 1);
    chk("mul_busy0", bus.md_busy, 0);
    chk_run("mul_t0");
    for (int k = 1; k <= 4; k++) begin
      nxt(); bus.id_is_md = 0; bus.id_reads_hilo = 1;
      #3 chk("mul_busy", bus.md_busy, 1);
      chk("mul_done", bus.md_done, (k == 4));
      chk("mul_nostart", bus.md_start, 0);
      chk_stall("mul_hilo"); exp_sc++;
    end
    nxt();
    #3 chk("mul_idle", bus.md_busy, 0);
    chk("mul_done_end", bus.md_done, 0);
    chk_run("mul_t5");
    chk("mul_sc", bus.stall_count, exp_sc);

    // Back-to-back div
    nxt(); clr_in();
    bus.id_is_md = 1; bus.id_md_div = 1;
    #3 chk("div1_start", bus.md_start, 1);
    for (int k = 1; k <= 8; k++) begin
      nxt();
      #3 chk("div1_busy", bus.md_busy, 1);
      chk("div1_nostart", bus.md_start, 0);
      chk("div1_done", bus.md_done, (k == 8));
      chk_stall("div1_hold"); exp_sc++;
    end
    nxt();
    #3 chk("div2_start", bus.md_start, 1);
    chk("div2_busy0", bus.md_busy, 0);
    chk_run("div2_t9");
    // Second div: freeze, mfhi and a simultaneous load-use must not delay completion.
    for (int k = 1; k <= 8; k++) begin
      nxt(); clr_in();
      bus.freeze = 1; bus.id_reads_hilo = 1;
      if (k == 3) begin
        bus.ex_load = 1; bus.ex_rd = 9; bus.id_uses_rs = 1; bus.id_rs = 9;
      end
      #3 chk("div2_busy", bus.md_busy, 1);
      chk("div2_done", bus.md_done, (k == 8));
      chk_stall("div2_frz"); exp_sc++;
    end
    nxt(); clr_in();
    #3 chk("div2_idle", bus.md_busy, 0);
    chk_run("div2_end");
    chk("div2_sc", bus.stall_count, exp_sc);

    // Reset in the middle of a div
    nxt(); clr_in();
    bus.id_is_md = 1; bus.id_md_div = 1;
    #3 chk("rdiv_start", bus.md_start, 1);
    for (int k = 1; k <= 2; k++) begin
      nxt(); bus.id_is_md = 0; bus.id_reads_hilo = 1;
      #3 chk("rdiv_busy", bus.md_busy, 1);
    end
    nxt(); #1 Reset_n = 0;
    #1 chk("rdiv_busy_rst", bus.md_busy, 0);
    chk("rdiv_done_rst", bus.md_done, 0);
    chk("rdiv_sc_rst", bus.stall_count, 0);
    chk_run("rdiv_rst");
    @(negedge Clk) Reset_n = 1;
    exp_sc = 0;
    for (int k = 0; k < 10; k++) begin
      nxt();
      #3 chk("rdiv_nodone", bus.md_done, 0);
      chk("rdiv_idle", bus.md_busy, 0);
      chk("rdiv_pc", bus.pc_le, 1);
    end
    chk("rdiv_sc", bus.stall_count, exp_sc);

    // Saturation with a 4-bit stall counter
    nxt(); clr_in(); bus4.freeze = 1;
    for (int k = 1; k <= 20; k++) begin
      nxt();
      #3 chk("sat_sc", bus4.stall_count, (k > 15) ? 15 : k);
    end
    nxt(); clr_in();
    #3 chk("sat_hold", bus4.stall_count, 15);
    chk("sat_main_sc", bus.stall_count, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
